conv3x3_stream: RTL and testbench
=================================

// Module: conv3x3_stream
// PURPOSE
//  Streaming 3x3 convolution over a raster-scan IMG_W x IMG_H feature map; generalises the 1-bit fixed-kernel LUT conv.
//  Multi-bit unsigned pixels, run-time loadable signed kernel + bias (double-buffered), per-frame counters,
//  valid-window-only output, round-free shift and signed saturation. Sits between pixel source and pooling/next layer.
// PARAMETERS
//  IMG_W   34  pixels per row (>=3)
//  IMG_H   34  rows per frame (>=3)
//  DIN_W   1   unsigned pixel width
//  COEF_W  8   signed kernel/bias width
//  SHIFT   0   arithmetic right shift applied to sum before saturation
//  DOUT_W  8   signed output width
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       synchronous, active-low reset
//  din_valid    in   1       pixel strobe; one pixel accepted per high cycle
//  din          in   DIN_W   unsigned pixel, raster order
//  coef_we      in   1       write shadow coefficient bank
//  coef_addr    in   4       0..8 kernel k[0]=top-left .. k[8]=bottom-right (row-major); 9 = bias; 10..15 ignored
//  coef_data    in   COEF_W  signed coefficient/bias value
//  coef_commit  in   1       request shadow->active bank copy
//  dout_valid   out  1       dout holds a valid convolution result
//  dout         out  DOUT_W  signed saturated result
//  frame_done   out  1       1-cycle pulse after last pixel of frame accepted
//  busy         out  1       high in RUN (frame partially received)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): dout_valid=0, dout=0, frame_done=0, busy=0; row/col counters, line buffers, window,
//   pipeline valids cleared; active and shadow banks and bias = 0; pending-commit flag = 0. Applies mid-frame: frame restarts.
//  FSM: IDLE -> RUN on first accepted pixel; RUN -> IDLE on accepting pixel (IMG_H-1, IMG_W-1) (frame_done pulses next cycle).
//  Counters: col 0..IMG_W-1 wraps to 0 and row++; row wraps to 0 at frame end. Advance only on din_valid.
//  Line buffer: 2 rows of IMG_W pixels + 3x3 window shift on din_valid only; gaps in din_valid never alter results.
//  Window position valid iff accepted pixel has row>=2 and col>=2; no padding; (IMG_W-2)*(IMG_H-2) outputs per frame.
//  Window wrap-around across row boundary (col 0,1) never produces output.
//  Arithmetic: p[i] zero-extended to signed; sum = bias + SUM k[i]*p[i], ACC_W = DIN_W+COEF_W+5 (no overflow);
//   y = sum >>> SHIFT; dout = clamp(y, -2^(DOUT_W-1), 2^(DOUT_W-1)-1).
//  Latency: fixed 3 clk from accepting the completing pixel to dout_valid (S1 window/products, S2 adder tree, S3 shift/sat).
//   Pipeline advances every cycle regardless of din_valid; dout_valid high 1 cycle per result; dout holds value while low.
//  Coefficients: coef_we writes shadow every cycle regardless of state. coef_commit in IDLE: copy shadow->active next edge.
//   coef_commit in RUN: set pending; copy at the edge the FSM returns to IDLE; whole frame always uses one kernel.
//   coef_we + coef_commit same cycle: the write is included in the committed bank. Repeated commits while pending: idempotent.
//   Commit coinciding with frame-last pixel: applied at that edge, effective for next frame.
//  Results in flight when active bank changes were computed at S1 with old bank (S1 multiplies by bank of its frame).
// STRUCTURE
//  Package cnn_pkg: ACC_W function, KIDX_BIAS=9 constant, sat_signed() function, kernel index constants.
//  Sub-module conv_line_buffer (IMG_W, DIN_W): 2-row delay + 3x3 window regs, en=din_valid, outputs 9 pixels.
//  Top: counters/FSM, coefficient banks, 3-stage MAC pipeline.
// TESTING
//  IMG 5x5, DIN_W=1, k=all 1, bias 0, all-ones image -> exactly 9 dout_valid pulses, each dout=9; frame_done once.
//  IMG 5x5, DIN_W=8, k[4]=1 else 0, pixel=raster index 0..24 -> dout sequence 6,7,8,11,12,13,16,17,18.
//  DIN_W=8, k=all 127, bias 127, pixels 255 -> dout=127; k=all -128 -> dout=-128 (saturation both rails).
//  Same as test 2 with din_valid random 50% duty -> identical dout sequence, latency 3 clk from completing pixel.
//  Commit k=all 1 mid-frame after k[4]=1 -> current frame outputs unchanged; next frame uses new kernel.
//  rst_n low at pixel 12, then full frame -> no stale outputs, first result after row 2 col 2, values match test 2.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants, state type and arithmetic helpers for the 3x3 conv stream
package cnn_pkg;
  localparam int NTAPS = 9;
  localparam int KIDX_BIAS = 9;
  localparam int NCOEF = 10;
  typedef enum logic {S_IDLE, S_RUN} conv_state_e;
  function automatic int acc_w(input int din_w, input int coef_w);
    return din_w + coef_w + 5;
  endfunction
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: two-row delay line feeding a 3x3 window; win shows the window including the incoming pixel
module conv_line_buffer import cnn_pkg::*; #(
  parameter int IMG_W = 34,
  parameter int DIN_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  output logic [DIN_W-1:0] win [NTAPS]
);
  logic [DIN_W-1:0] row0_q [IMG_W];
  logic [DIN_W-1:0] row0_d [IMG_W];
  logic [DIN_W-1:0] row1_q [IMG_W];
  logic [DIN_W-1:0] row1_d [IMG_W];
  logic [DIN_W-1:0] win_q [NTAPS];
  logic [DIN_W-1:0] win_d [NTAPS];
  // shift both row delays and slide the window one column left when a pixel is accepted
  always_comb begin
    row0_d = row0_q;
    row1_d = row1_q;
    win_d = win_q;
    if (en) begin
      for (int i = IMG_W - 1; i > 0; i--) begin
        row0_d[i] = row0_q[i-1];
        row1_d[i] = row1_q[i-1];
      end
      row0_d[0] = din;
      row1_d[0] = row0_q[IMG_W-1];
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = row1_q[IMG_W-1];
      win_d[5] = row0_q[IMG_W-1];
      win_d[8] = din;
    end
  end
  // delay-line and window registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row0_q <= '{default: '0};
      row1_q <= '{default: '0};
      win_q  <= '{default: '0};
    end else begin
      row0_q <= row0_d;
      row1_q <= row1_d;
      win_q  <= win_d;
    end
  end
  assign win = win_d;
endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: raster-scan 3x3 convolution with double-buffered kernel and saturating 3-stage MAC
module conv3x3_stream import cnn_pkg::*; #(
  parameter int IMG_W  = 34,
  parameter int IMG_H  = 34,
  parameter int DIN_W  = 1,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 0,
  parameter int DOUT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din_valid,
  input  logic [DIN_W-1:0]         din,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_commit,
  output logic                     dout_valid,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     frame_done,
  output logic                     busy
);
  localparam int ACC_W = acc_w(DIN_W, COEF_W);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  conv_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic signed [COEF_W-1:0] shadow_q [NCOEF];
  logic signed [COEF_W-1:0] shadow_d [NCOEF];
  logic signed [COEF_W-1:0] active_q [NCOEF];
  logic signed [COEF_W-1:0] active_d [NCOEF];
  logic pend_q, pend_d;
  logic signed [ACC_W-1:0] prod_q [NCOEF];
  logic signed [ACC_W-1:0] prod_d [NCOEF];
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic v1_q, v1_d, v2_q, v2_d, dout_valid_q, dout_valid_d, frame_done_q, frame_done_d;
  logic signed [DOUT_W-1:0] dout_q, dout_d;
  logic [DIN_W-1:0] win [NTAPS];
  logic last, win_ok, commit_now;
  logic signed [63:0] y;
  conv_line_buffer #(.IMG_W(IMG_W), .DIN_W(DIN_W)) u_lb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (din_valid),
    .din  (din),
    .win  (win)
  );
  // raster counters and IDLE/RUN frame tracking; a frame ends on accepting its bottom-right pixel
  always_comb begin
    last = din_valid && row_q == RW'(IMG_H - 1) && col_q == CW'(IMG_W - 1);
    win_ok = din_valid && row_q >= RW'(2) && col_q >= CW'(2);
    col_d = !din_valid ? col_q : col_q == CW'(IMG_W - 1) ? '0 : col_q + 1'b1;
    row_d = !din_valid || col_q != CW'(IMG_W - 1) ? row_q : last ? '0 : row_q + 1'b1;
    state_d = last ? S_IDLE : din_valid ? S_RUN : state_q;
    frame_done_d = last;
  end
  // shadow writes any time; shadow->active copy only between frames so a frame never mixes kernels
  always_comb begin
    shadow_d = shadow_q;
    if (coef_we && coef_addr <= 4'(KIDX_BIAS)) shadow_d[coef_addr] = coef_data;
    commit_now = (state_q == S_IDLE && coef_commit) || (last && (pend_q || coef_commit));
    active_d = active_q;
    if (commit_now) active_d = shadow_d;
    pend_d = !commit_now && (pend_q || (coef_commit && state_q == S_RUN));
  end
  // S1 products use the bank active at acceptance, S2 sums, S3 shifts and saturates
  always_comb begin
    for (int i = 0; i < NTAPS; i++) prod_d[i] = $signed(ACC_W'(win[i])) * ACC_W'(active_q[i]);
    prod_d[KIDX_BIAS] = ACC_W'(active_q[KIDX_BIAS]);
    v1_d = win_ok;
    sum_d = '0;
    for (int i = 0; i < NCOEF; i++) sum_d = sum_d + prod_q[i];
    v2_d = v1_q;
    y = 64'(sum_q >>> SHIFT);
    dout_valid_d = v2_q;
    dout_d = v2_q ? DOUT_W'(sat_signed(y, DOUT_W)) : dout_q;
  end
  // state, coefficient and pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      shadow_q     <= '{default: '0};
      active_q     <= '{default: '0};
      pend_q       <= 1'b0;
      prod_q       <= '{default: '0};
      sum_q        <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      prod_q       <= prod_d;
      sum_q        <= sum_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign dout_valid = dout_valid_q;
  assign dout = dout_q;
  assign frame_done = frame_done_q;
  assign busy = state_q == S_RUN;
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: scoreboard bench for a 5x5 8-bit instance of conv3x3_stream
module tb_conv3x3_stream;
  localparam int W = 5;
  localparam int H = 5;
  localparam int DW = 8;
  localparam int KW = 8;
  localparam int OW = 8;
  typedef struct {
    int val;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic signed [KW-1:0] coef_data = '0;
  logic coef_commit = 1'b0;
  logic dout_valid, frame_done, busy;
  logic signed [OW-1:0] dout;
  exp_t sb[$];
  int got[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int img[W*H];
  int r = 0;
  int c = 0;
  int cur_k[10];
  int new_k[10];
  int center_seq[9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

  always #5 clk = ~clk;

  conv3x3_stream #(.IMG_W(W), .IMG_H(H), .DIN_W(DW), .COEF_W(KW), .SHIFT(0), .DOUT_W(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_commit(coef_commit),
    .dout_valid (dout_valid),
    .dout       (dout),
    .frame_done (frame_done),
    .busy       (busy)
  );

  // falling-edge monitor: pops the scoreboard on every result and checks value and arrival cycle
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (frame_done === 1'b1) fd_cnt++;
    if (dout_valid === 1'b1) begin
      got.push_back(int'(dout));
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output dout=%0d at cycle %0d, nothing expected", dout, cyc);
      end else begin
        e = sb.pop_front();
        if (int'(dout) !== e.val || cyc !== e.cyc) begin
          n_err++;
          $display("FAIL scoreboard dout=%0d cycle=%0d, required %0d at cycle %0d", dout, cyc, e.val, e.cyc);
        end
      end
    end
  end

  function automatic int conv_at(int rr, int cc);
    int s;
    s = cur_k[9];
    for (int i = 0; i < 9; i++) s += cur_k[i] * img[(rr - 2 + i / 3) * W + cc - 2 + i % 3];
    return s > 127 ? 127 : s < -128 ? -128 : s;
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      coef_we = 1'b0;
      coef_commit = 1'b0;
    end
  endtask

  // the pixel is accepted at the next rising edge; its result is registered two edges
  // after that and is first seen on the fourth falling edge from now
  task automatic send(int v);
    @(posedge clk);
    #1;
    din_valid = 1'b1;
    din = DW'(v);
    coef_we = 1'b0;
    coef_commit = 1'b0;
    img[r*W+c] = v;
    if (r >= 2 && c >= 2) sb.push_back('{conv_at(r, c), cyc + 4});
    c++;
    if (c == W) begin
      c = 0;
      r = r == H - 1 ? 0 : r + 1;
    end
  endtask

  // kind 0: all ones, 1: raster index, 2: 255
  task automatic send_range(int kind, int lo, int hi, bit gaps);
    for (int i = lo; i <= hi; i++) begin
      send(kind == 0 ? 1 : kind == 1 ? i : 255);
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

  task automatic write_coefs(bit commit);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      coef_we = 1'b1;
      coef_addr = 4'(i);
      coef_data = KW'(new_k[i]);
      coef_commit = commit && i == 9;
    end
    idle(1);
  endtask

  task automatic set_center();
    for (int i = 0; i < 10; i++) new_k[i] = i == 4 ? 1 : 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_vec += 4;
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dout_valid got %b want 0", dout_valid); end
    if (dout !== 8'sd0) begin n_err++; $display("FAIL reset_dout got %0d want 0", dout); end
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_all_ones();
    int fd0;
    for (int i = 0; i < 10; i++) new_k[i] = i == 9 ? 0 : 1;
    write_coefs(1'b1);
    cur_k = new_k;
    got.delete();
    fd0 = fd_cnt;
    send_range(0, 0, W * H - 1, 1'b0);
    idle(6);
    n_vec += 4;
    if (got.size() != 9) begin n_err++; $display("FAIL ones_count got %0d want 9", got.size()); end
    if (fd_cnt - fd0 != 1) begin n_err++; $display("FAIL ones_frame_done got %0d want 1", fd_cnt - fd0); end
    if (sb.size() != 0) begin n_err++; $display("FAIL ones_missing got %0d pending want 0", sb.size()); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL ones_busy_after got %b want 0", busy); end
    for (int i = 0; i < got.size(); i++) begin
      n_vec++;
      if (got[i] != 9) begin n_err++; $display("FAIL ones_value[%0d] got %0d want 9", i, got[i]); end
    end
  endtask

  task automatic test_center(bit gaps);
    set_center();
    write_coefs(1'b1);
    cur_k = new_k;
    got.delete();
    send_range(1, 0, W * H - 1, gaps);
    idle(6);
    n_vec += 2;
    if (got.size() != 9) begin n_err++; $display("FAIL center_count gaps=%0d got %0d want 9", gaps, got.size()); end
    if (sb.size() != 0) begin n_err++; $display("FAIL center_missing got %0d pending want 0", sb.size()); end
    for (int i = 0; i < 9; i++) begin
      int g;
      g = i < got.size() ? got[i] : -999;
      n_vec++;
      if (g != center_seq[i]) begin n_err++; $display("FAIL center_seq[%0d] gaps=%0d got %0d want %0d", i, gaps, g, center_seq[i]); end
    end
  endtask

  task automatic test_saturation();
    for (int pass = 0; pass < 2; pass++) begin
      int want;
      want = pass == 0 ? 127 : -128;
      for (int i = 0; i < 10; i++) new_k[i] = want;
      write_coefs(1'b1);
      cur_k = new_k;
      got.delete();
      send_range(2, 0, W * H - 1, 1'b0);
      idle(6);
      n_vec += 2;
      if (got.size() != 9) begin n_err++; $display("FAIL sat_count got %0d want 9", got.size()); end
      if (sb.size() != 0) begin n_err++; $display("FAIL sat_missing got %0d pending want 0", sb.size()); end
      for (int i = 0; i < got.size(); i++) begin
        n_vec++;
        if (got[i] != want) begin n_err++; $display("FAIL sat_rail[%0d] got %0d want %0d", i, got[i], want); end
      end
    end
  endtask

  task automatic test_mid_commit();
    set_center();
    write_coefs(1'b1);
    cur_k = new_k;
    got.delete();
    send_range(1, 0, 9, 1'b0);
    for (int i = 0; i < 10; i++) new_k[i] = i == 9 ? 0 : 1;
    write_coefs(1'b1);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL midcommit_busy got %b want 1", busy); end
    send_range(1, 10, W * H - 1, 1'b0);
    idle(6);
    for (int i = 0; i < 9; i++) begin
      int g;
      g = i < got.size() ? got[i] : -999;
      n_vec++;
      if (g != center_seq[i]) begin n_err++; $display("FAIL midcommit_old[%0d] got %0d want %0d", i, g, center_seq[i]); end
    end
    cur_k = new_k;
    got.delete();
    send_range(1, 0, W * H - 1, 1'b0);
    idle(6);
    n_vec += 3;
    if (got.size() != 9) begin n_err++; $display("FAIL midcommit_count got %0d want 9", got.size()); end
    if (got.size() > 0 && got[0] != 54) begin n_err++; $display("FAIL midcommit_new got %0d want 54", got[0]); end
    if (sb.size() != 0) begin n_err++; $display("FAIL midcommit_missing got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_reset_midframe();
    int fd0;
    set_center();
    write_coefs(1'b1);
    cur_k = new_k;
    send_range(1, 0, 10, 1'b0);
    send(11);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    din_valid = 1'b1;
    din = DW'(12);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    r = 0;
    c = 0;
    n_vec += 3;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_dout_valid got %b want 0", dout_valid); end
    if (sb.size() != 0) begin n_err++; $display("FAIL rstmid_pending got %0d want 0", sb.size()); end
    write_coefs(1'b1);
    got.delete();
    fd0 = fd_cnt;
    send_range(1, 0, W * H - 1, 1'b0);
    idle(6);
    n_vec += 2;
    if (fd_cnt - fd0 != 1) begin n_err++; $display("FAIL rstmid_frame_done got %0d want 1", fd_cnt - fd0); end
    if (got.size() != 9) begin n_err++; $display("FAIL rstmid_count got %0d want 9", got.size()); end
    for (int i = 0; i < 9; i++) begin
      int g;
      g = i < got.size() ? got[i] : -999;
      n_vec++;
      if (g != center_seq[i]) begin n_err++; $display("FAIL rstmid_seq[%0d] got %0d want %0d", i, g, center_seq[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_center(1'b0);
    test_saturation();
    test_center(1'b1);
    test_mid_commit();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
